// File: rtl/dte_diag_reader.sv
// EBUS diagnostic register reader: strobes DIAG selectors and returns sampled words.
// Optional parity on returned data when DTE_DIAG_PARITY_EN is defined.
module dte_diag_reader #(
    parameter int unsigned SETTLE_CYCLES  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [2:0]  reqSel,
    input  logic        reqDump,
    output logic [2:0]  diagSel,
    output logic        diagReadFunc12x,
    input  logic        ebusDriving,
    input  logic [0:35] ebusData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [2:0]  rspSel,
    output logic [0:35] rspData,
    output logic        rspTimeout,
    output logic        rspLast,
    output logic        rspParity,
    output logic        busy
);

    localparam logic [7:0] SettleCnt  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic        dump_q, dump_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [0:35] data_q, data_d;
    logic        timeout_q, timeout_d;
    logic        last_q, last_d;
    logic        capture;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dump_d    = dump_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        timeout_d = timeout_q;
        last_d    = last_q;
        capture   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (reqValid) begin
                    sel_d   = reqDump ? 3'd0 : reqSel;
                    dump_d  = reqDump;
                    cnt_d   = 8'd1;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                // Once settled, the first cycle with a driver wins over the timeout.
                if (cnt_q >= SettleCnt && ebusDriving) begin
                    data_d    = ebusData;
                    timeout_d = 1'b0;
                    last_d    = !dump_q || (sel_q == 3'd7);
                    capture   = 1'b1;
                    state_d   = StResp;
                end else if (cnt_q >= TimeoutCnt) begin
                    data_d    = '0;
                    timeout_d = 1'b1;
                    last_d    = 1'b1;
                    capture   = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (rspReady) begin
                    if (last_q) begin
                        state_d = StIdle;
                    end else begin
                        sel_d   = sel_q + 3'd1;
                        cnt_d   = 8'd1;
                        state_d = StDrive;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            dump_q    <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            dump_q    <= dump_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
        end
    end

`ifdef DTE_DIAG_PARITY_EN
    logic parity_q;

    // Timeout loads zero data, so its parity is zero as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (capture) begin
            parity_q <= ^data_d;
        end
    end

    assign rspParity = parity_q;
`else
    assign rspParity = 1'b0;
`endif

    assign reqReady        = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign diagReadFunc12x = (state_q == StDrive);
    assign diagSel         = sel_q;
    assign rspValid        = (state_q == StResp);
    assign rspSel          = sel_q;
    assign rspData         = data_q;
    assign rspTimeout      = timeout_q;
    assign rspLast         = last_q;

endmodule

// File: tb/tb_dte_diag_reader.sv
// Self-checking bench for dte_diag_reader with a cycle-level behavioural reference.
module tb_dte_diag_reader;

    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  reqSel;
    logic        reqDump;
    logic [2:0]  diagSel;
    logic        diagReadFunc12x;
    logic        ebusDriving;
    logic [0:35] ebusData;
    logic        rspValid;
    logic        rspReady;
    logic [2:0]  rspSel;
    logic [0:35] rspData;
    logic        rspTimeout;
    logic        rspLast;
    logic        rspParity;
    logic        busy;

    int tests = 0;
    int fails = 0;

    dte_diag_reader #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqSel         (reqSel),
        .reqDump        (reqDump),
        .diagSel        (diagSel),
        .diagReadFunc12x(diagReadFunc12x),
        .ebusDriving    (ebusDriving),
        .ebusData       (ebusData),
        .rspValid       (rspValid),
        .rspReady       (rspReady),
        .rspSel         (rspSel),
        .rspData        (rspData),
        .rspTimeout     (rspTimeout),
        .rspLast        (rspLast),
        .rspParity      (rspParity),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] rand36();
        return 36'({$urandom, $urandom});
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        tests++;
        if ({reqReady, rspValid, diagReadFunc12x, diagSel, rspSel, rspTimeout, rspLast,
             rspParity, busy} !== {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b strb=%b dsel=%0d rsel=%0d to=%b last=%b par=%b busy=%b",
                     reqReady, rspValid, diagReadFunc12x, diagSel, rspSel, rspTimeout, rspLast,
                     rspParity, busy);
        end
        tests++;
        if (rspData !== 36'd0) begin
            fails++;
            $display("FAIL reset_data: got %o want 0", rspData);
        end
    endtask

    // Presents one request while idle; returns positioned in DRIVE cycle 1.
    task automatic send_req(input logic [2:0] sel, input bit dump);
        int waited = 0;
        while (!reqReady && waited < 50) begin
            step();
            waited++;
        end
        tests++;
        if (!reqReady) begin
            fails++;
            $display("FAIL req_ready_wait: got 0 want 1");
        end
        reqValid = 1'b1;
        reqSel   = sel;
        reqDump  = dump;
        step();
        reqValid = 1'b0;
        reqSel   = $urandom_range(0, 7);
        reqDump  = $urandom_range(0, 1);
    endtask

    // One word: the bus driver appears at DRIVE cycle d (NEVER = absent).
    task automatic run_word(input int esel, input int d, input logic [35:0] dat, input bit dump,
                            input int stall, input bit hold_req, output bit ok);
        int c = 1;
        int exp_c;
        bit to;
        bit got = 0;
        logic [35:0] edata;
        bit elast;
        bit epar;
        logic [35:0] sd;
        to    = (d > TIMEOUT);
        exp_c = (to ? TIMEOUT : ((d > SETTLE) ? d : SETTLE)) + 1;
        edata = to ? 36'd0 : dat;
        elast = !dump || (esel == 7) || to;
`ifdef DTE_DIAG_PARITY_EN
        epar = ^edata;
`else
        epar = 1'b0;
`endif
        if (hold_req) begin
            reqValid = 1'b1;
            reqSel   = 3'(esel + 3);
        end
        while (c <= TIMEOUT + 3 && !got) begin
            if (rspValid) begin
                got = 1;
            end else begin
                tests++;
                if ({diagReadFunc12x, diagSel, busy, reqReady} !== {1'b1, 3'(esel), 1'b1, 1'b0}) begin
                    fails++;
                    $display("FAIL drive_cycle%0d: got strb=%b dsel=%0d busy=%b rdy=%b want 1 %0d 1 0",
                             c, diagReadFunc12x, diagSel, busy, reqReady, esel);
                end
                ebusDriving = (c >= d);
                ebusData    = (c >= d) ? dat : rand36();
                step();
                c++;
            end
        end
        ok = got;
        tests++;
        if (!got || c != exp_c) begin
            fails++;
            $display("FAIL rsp_latency: got cycle %0d (seen=%b) want %0d", c, got, exp_c);
        end
        if (got) begin
            tests++;
            if ({rspSel, rspData, rspTimeout, rspLast, rspParity, diagReadFunc12x} !==
                {3'(esel), edata, to, elast, epar, 1'b0}) begin
                fails++;
                $display("FAIL rsp_word: got sel=%0d data=%o to=%b last=%b par=%b strb=%b want %0d %o %b %b %b 0",
                         rspSel, rspData, rspTimeout, rspLast, rspParity, diagReadFunc12x,
                         esel, edata, to, elast, epar);
            end
            sd = rspData;
            rspReady = 1'b0;
            for (int i = 0; i < stall; i++) begin
                ebusDriving = $urandom_range(0, 1);
                ebusData    = rand36();
                step();
                tests++;
                if ({rspValid, rspSel, rspData, rspTimeout, rspLast, rspParity, diagReadFunc12x} !==
                    {1'b1, 3'(esel), sd, to, elast, epar, 1'b0}) begin
                    fails++;
                    $display("FAIL stall_hold: got vld=%b sel=%0d data=%o to=%b last=%b par=%b strb=%b",
                             rspValid, rspSel, rspData, rspTimeout, rspLast, rspParity, diagReadFunc12x);
                end
            end
            reqValid = 1'b0;
            rspReady = 1'b1;
            step();
            rspReady = 1'b0;
        end
    endtask

    // Full request; the word sequence and its end come from the reference model.
    task automatic run_request(input logic [2:0] sel, input bit dump, input int d, input bit rnd,
                               input logic [35:0] dat, input int stall, input bit hold_req);
        int s;
        int dd;
        int st;
        bit done = 0;
        bit ok = 1;
        logic [35:0] wd;
        send_req(sel, dump);
        s = dump ? 0 : int'(sel);
        while (!done && ok) begin
            if (rnd) begin
                dd = ($urandom_range(0, 3) == 0) ? $urandom_range(SETTLE + 1, TIMEOUT + 2)
                                                 : $urandom_range(1, SETTLE);
                wd = rand36();
                st = $urandom_range(0, 2);
            end else begin
                dd = d;
                wd = dump ? 36'(s) : dat;
                st = stall;
            end
            run_word(s, dd, wd, dump, st, hold_req, ok);
            done = !dump || (s == 7) || (dd > TIMEOUT);
            s++;
        end
        tests++;
        if ({reqReady, busy, rspValid} !== 3'b100) begin
            fails++;
            $display("FAIL end_idle: got rdy=%b busy=%b vld=%b want 1 0 0", reqReady, busy, rspValid);
        end
    endtask

    task automatic test_single();
        run_request(3'd3, 1'b0, 1, 1'b0, 36'o123456701234, 0, 1'b0);
    endtask

    task automatic test_dump();
        run_request(3'd5, 1'b1, 1, 1'b0, 36'd0, 1, 1'b0);
    endtask

    task automatic test_timeout();
        run_request(3'd5, 1'b0, NEVER, 1'b0, 36'o777, 0, 1'b0);
    endtask

    task automatic test_late_driver();
        run_request(3'd1, 1'b0, 7, 1'b0, 36'o55555, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_request(3'd6, 1'b0, 2, 1'b0, 36'o707070707070, 10, 1'b0);
    endtask

    task automatic test_parity();
        run_request(3'd2, 1'b0, 1, 1'b0, 36'o000000000007, 0, 1'b0);
        run_request(3'd4, 1'b0, 1, 1'b0, 36'o000000000003, 0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_request(3'd2, 1'b0, 4, 1'b0, 36'o1234, 2, 1'b1);
        repeat (3) begin
            step();
            tests++;
            if ({rspValid, diagReadFunc12x, busy} !== 3'b000) begin
                fails++;
                $display("FAIL no_queue: got vld=%b strb=%b busy=%b want 0 0 0",
                         rspValid, diagReadFunc12x, busy);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        send_req(3'd0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            run_word(s, 1, 36'(s), 1'b1, 0, 1'b0, ok);
        end
        ebusDriving = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if ({busy, reqReady, rspValid, diagReadFunc12x} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_mid_dump: got busy=%b rdy=%b vld=%b strb=%b want 0 1 0 0",
                     busy, reqReady, rspValid, diagReadFunc12x);
        end
        repeat (6) begin
            step();
            tests++;
            if ({rspValid, diagReadFunc12x} !== 2'b00) begin
                fails++;
                $display("FAIL after_reset_quiet: got vld=%b strb=%b want 0 0",
                         rspValid, diagReadFunc12x);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_request(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 1'b1, 36'd0, 0,
                        1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        reset       = 1'b1;
        reqValid    = 1'b0;
        reqSel      = 3'd0;
        reqDump     = 1'b0;
        ebusDriving = 1'b0;
        ebusData    = '0;
        rspReady    = 1'b0;
        test_reset();
        test_single();
        test_dump();
        test_timeout();
        test_late_driver();
        test_backpressure();
        test_parity();
        test_busy_ignore();
        test_reset_mid_dump();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
